// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan scheduler for the eight-register seven-segment path.
// Cycles four active-low digit selects over four register pairs, blanks the
// start of every phase to suppress ghosting, and serves the decoders from a
// shadow copy of the register file that is refreshed only at frame edges.
module disp_scan_ctrl #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         freeze,
    input  logic         snap_req,
    input  logic [127:0] regs_in,
    output logic [3:0]   sel_n,
    output logic         blank,
    output logic [1:0]   phase,
    output logic [15:0]  disp_lo,
    output logic [15:0]  disp_hi,
    output logic         frame_done,
    output logic         snap_ack
);

    localparam int unsigned     CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_LOAD,
        S_SCAN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_phase;
    logic [3:0]       r_sel_n;
    logic             r_blank;
    logic             r_req;
    logic             r_ack;
    logic [15:0]      r_shadow [8];

    logic             w_frame_end;
    logic             w_load;
    logic [31:0]      w_cnt_inc;

    // Active-low select pattern for a given pair index.
    function automatic logic [3:0] sel_pattern(input logic [1:0] ph);
        case (ph)
            2'd0:    sel_pattern = 4'b0111;
            2'd1:    sel_pattern = 4'b1011;
            2'd2:    sel_pattern = 4'b1101;
            default: sel_pattern = 4'b1110;
        endcase
    endfunction

    // Frame boundary and shadow-load decode; a request arriving on the load
    // edge itself is honoured by that same load.
    always_comb begin
        w_frame_end = (r_state == S_SCAN) && (r_phase == 2'd3) && (r_cnt == CNT_MAX);
        w_load      = (r_state == S_LOAD) ||
                      (w_frame_end && (!freeze || r_req || snap_req));
        w_cnt_inc   = 32'(r_cnt) + 32'd1;
    end

    // Scan FSM; select and blank are registered from the next count/phase so
    // the outputs line up with the counter without any combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_phase <= 2'd0;
            r_sel_n <= 4'b1111;
            r_blank <= 1'b1;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_cnt   <= '0;
                    r_phase <= 2'd0;
                    r_sel_n <= 4'b1111;
                    r_blank <= 1'b1;
                    if (en) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_state <= S_SCAN;
                    r_cnt   <= '0;
                    r_phase <= 2'd0;
                    r_sel_n <= 4'b1111;
                    r_blank <= 1'b1;
                end
                S_SCAN: begin
                    if (!en) begin
                        r_state <= S_OFF;
                        r_cnt   <= '0;
                        r_phase <= 2'd0;
                        r_sel_n <= 4'b1111;
                        r_blank <= 1'b1;
                    end else if (r_cnt == CNT_MAX) begin
                        r_cnt   <= '0;
                        r_phase <= r_phase + 2'd1;
                        r_sel_n <= 4'b1111;
                        r_blank <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_cnt_inc >= BLANK) begin
                            r_sel_n <= sel_pattern(r_phase);
                            r_blank <= 1'b0;
                        end else begin
                            r_sel_n <= 4'b1111;
                            r_blank <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_cnt   <= '0;
                    r_phase <= 2'd0;
                    r_sel_n <= 4'b1111;
                    r_blank <= 1'b1;
                end
            endcase
        end
    end

    // Snapshot request flag and one-cycle acknowledge after a servicing load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= 1'b0;
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_load && (r_req || snap_req);
            if (w_load) r_req <= 1'b0;
            else if (snap_req) r_req <= 1'b1;
        end
    end

    // Shadow register bank, captured on LOAD and on qualifying frame edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) r_shadow[k] <= 16'h0000;
        end else if (w_load) begin
            for (int k = 0; k < 8; k++) r_shadow[k] <= regs_in[16*k +: 16];
        end
    end

    assign sel_n      = r_sel_n;
    assign blank      = r_blank;
    assign phase      = r_phase;
    assign frame_done = w_frame_end;
    assign snap_ack   = r_ack;
    assign disp_lo    = r_shadow[{r_phase, 1'b0}];
    assign disp_hi    = r_shadow[{r_phase, 1'b1}];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV=8, BLANK=2 (32-cycle frames).
module tb_disp_scan_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         freeze;
    logic         snap_req;
    logic [127:0] regs_in;
    logic [3:0]   sel_n;
    logic         blank;
    logic [1:0]   phase;
    logic [15:0]  disp_lo;
    logic [15:0]  disp_hi;
    logic         frame_done;
    logic         snap_ack;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    disp_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .freeze     (freeze),
        .snap_req   (snap_req),
        .regs_in    (regs_in),
        .sel_n      (sel_n),
        .blank      (blank),
        .phase      (phase),
        .disp_lo    (disp_lo),
        .disp_hi    (disp_hi),
        .frame_done (frame_done),
        .snap_ack   (snap_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [15:0] base);
        for (int k = 0; k < 8; k++) regs_in[16*k +: 16] = base + 16'(k);
    endtask

    task automatic wait_phase(input logic [1:0] p);
        int n = 0;
        while (phase !== p && n < 40) begin tick(); n++; end
        n_total++;
        if (phase !== p) $display("FAIL wait_phase: phase=%0d required %0d", phase, p);
        else n_pass++;
    endtask

    task automatic wait_frame_done();
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin tick(); n++; end
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL wait_frame_done: timeout, frame_done=%b required 1", frame_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; freeze = 1'b0; snap_req = 1'b0; regs_in = '0;
        tick(); tick(); tick();
        n_total++; if (sel_n !== 4'b1111) $display("FAIL reset_sel_n: got %b required 1111", sel_n); else n_pass++;
        n_total++; if (blank !== 1'b1) $display("FAIL reset_blank: got %b required 1", blank); else n_pass++;
        n_total++; if (phase !== 2'd0) $display("FAIL reset_phase: got %0d required 0", phase); else n_pass++;
        n_total++; if (disp_lo !== 16'h0 || disp_hi !== 16'h0) $display("FAIL reset_disp: got %h/%h required 0000/0000", disp_lo, disp_hi); else n_pass++;
        n_total++; if (frame_done !== 1'b0 || snap_ack !== 1'b0) $display("FAIL reset_pulses: got fd=%b ack=%b required 0/0", frame_done, snap_ack); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    // en sampled in cycle 0; checks cycles 1..33 against the startup timeline
    // and the pair mux with reg_k = A000+k.
    task automatic test_startup_and_mux();
        logic [3:0] e_sel;
        logic       e_blank;
        int         p, cn;
        set_regs(16'hA000);
        en = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 1) begin
                p = 0; e_sel = 4'b1111; e_blank = 1'b1;
            end else begin
                p  = ((c - 2) / 8) % 4;
                cn = (c - 2) % 8;
                e_sel   = (cn < 2) ? 4'b1111 : PAT[p];
                e_blank = (cn < 2);
            end
            n_total++; if (sel_n !== e_sel) $display("FAIL startup_sel_n c%0d: got %b required %b", c, sel_n, e_sel); else n_pass++;
            n_total++; if (blank !== e_blank) $display("FAIL startup_blank c%0d: got %b required %b", c, blank, e_blank); else n_pass++;
            n_total++; if (phase !== 2'(p)) $display("FAIL startup_phase c%0d: got %0d required %0d", c, phase, p); else n_pass++;
            n_total++; if (frame_done !== (c == 33)) $display("FAIL startup_frame_done c%0d: got %b required %b", c, frame_done, (c == 33)); else n_pass++;
            if (c >= 2) begin
                n_total++;
                if (disp_lo !== 16'hA000 + 16'(2*p) || disp_hi !== 16'hA001 + 16'(2*p))
                    $display("FAIL pair_mux c%0d: got %h/%h required %h/%h", c, disp_lo, disp_hi,
                             16'hA000 + 16'(2*p), 16'hA001 + 16'(2*p));
                else n_pass++;
            end
        end
    endtask

    // Starts in the frame_done cycle left by the startup test.
    task automatic test_frozen();
        int p;
        freeze = 1'b1;
        tick();
        for (int i = 0; i < 96; i++) begin
            p = (i / 8) % 4;
            if (i % 4 == 0) begin
                n_total++;
                if (disp_lo !== 16'hA000 + 16'(2*p) || disp_hi !== 16'hA001 + 16'(2*p) || snap_ack !== 1'b0)
                    $display("FAIL frozen_hold i%0d: got %h/%h ack=%b required %h/%h ack=0", i, disp_lo, disp_hi,
                             snap_ack, 16'hA000 + 16'(2*p), 16'hA001 + 16'(2*p));
                else n_pass++;
            end
            if (i == 10) for (int k = 0; k < 8; k++) regs_in[16*k +: 16] = 16'h5A5A;
            tick();
        end
        tick(); tick(); tick();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        wait_frame_done();
        n_total++; if (snap_ack !== 1'b0) $display("FAIL frozen_ack_early: got %b required 0", snap_ack); else n_pass++;
        tick();
        n_total++; if (snap_ack !== 1'b1) $display("FAIL frozen_ack: got %b required 1", snap_ack); else n_pass++;
        n_total++; if (disp_lo !== 16'h5A5A || disp_hi !== 16'h5A5A) $display("FAIL frozen_new_data: got %h/%h required 5a5a/5a5a", disp_lo, disp_hi); else n_pass++;
        tick();
        n_total++; if (snap_ack !== 1'b0) $display("FAIL frozen_ack_width: got %b required 0", snap_ack); else n_pass++;
    endtask

    task automatic test_coincident();
        set_regs(16'hB000);
        wait_frame_done();
        snap_req = 1'b1;
        tick();
        n_total++; if (snap_ack !== 1'b1) $display("FAIL coincident_ack: got %b required 1", snap_ack); else n_pass++;
        n_total++; if (disp_lo !== 16'hB000 || disp_hi !== 16'hB001) $display("FAIL coincident_data: got %h/%h required b000/b001", disp_lo, disp_hi); else n_pass++;
        tick();
        snap_req = 1'b0;
        for (int j = 1; j < 32; j++) begin
            n_total++; if (snap_ack !== 1'b0) $display("FAIL second_ack_early j%0d: got %b required 0", j, snap_ack); else n_pass++;
            tick();
        end
        n_total++; if (snap_ack !== 1'b1) $display("FAIL second_ack: got %b required 1", snap_ack); else n_pass++;
    endtask

    task automatic test_enable_drop();
        wait_phase(2'd1);
        tick(); tick(); tick(); tick(); tick();
        n_total++; if (sel_n !== 4'b1011 || blank !== 1'b0) $display("FAIL drop_before: got %b/%b required 1011/0", sel_n, blank); else n_pass++;
        en = 1'b0;
        tick();
        n_total++; if (sel_n !== 4'b1111 || blank !== 1'b1 || phase !== 2'd0) $display("FAIL drop_off: got %b/%b/%0d required 1111/1/0", sel_n, blank, phase); else n_pass++;
        en = 1'b1;
        tick();
        n_total++; if (sel_n !== 4'b1111 || blank !== 1'b1 || phase !== 2'd0) $display("FAIL drop_load: got %b/%b/%0d required 1111/1/0", sel_n, blank, phase); else n_pass++;
        tick();
        n_total++; if (sel_n !== 4'b1111 || phase !== 2'd0 || snap_ack !== 1'b0) $display("FAIL drop_cnt0: got %b/%0d ack=%b required 1111/0 ack=0", sel_n, phase, snap_ack); else n_pass++;
        tick();
        n_total++; if (sel_n !== 4'b1111) $display("FAIL drop_cnt1: got %b required 1111", sel_n); else n_pass++;
        tick();
        n_total++; if (sel_n !== 4'b0111 || blank !== 1'b0) $display("FAIL drop_cnt2: got %b/%b required 0111/0", sel_n, blank); else n_pass++;
    endtask

    task automatic test_mid_reset();
        freeze = 1'b1;
        set_regs(16'hC000);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        wait_phase(2'd2);
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        n_total++; if (sel_n !== 4'b1111 || blank !== 1'b1 || phase !== 2'd0) $display("FAIL mrst_ctrl: got %b/%b/%0d required 1111/1/0", sel_n, blank, phase); else n_pass++;
        n_total++; if (disp_lo !== 16'h0 || disp_hi !== 16'h0) $display("FAIL mrst_shadow: got %h/%h required 0000/0000", disp_lo, disp_hi); else n_pass++;
        n_total++; if (frame_done !== 1'b0 || snap_ack !== 1'b0) $display("FAIL mrst_pulses: got %b/%b required 0/0", frame_done, snap_ack); else n_pass++;
        tick();
        en = 1'b1;
        tick();
        n_total++; if (snap_ack !== 1'b0 || disp_lo !== 16'h0) $display("FAIL mrst_load: got ack=%b lo=%h required 0/0000", snap_ack, disp_lo); else n_pass++;
        tick();
        n_total++; if (snap_ack !== 1'b0) $display("FAIL mrst_no_ack: got %b required 0", snap_ack); else n_pass++;
        n_total++; if (disp_lo !== 16'hC000 || disp_hi !== 16'hC001) $display("FAIL mrst_reload: got %h/%h required c000/c001", disp_lo, disp_hi); else n_pass++;
        tick();
        n_total++; if (snap_ack !== 1'b0) $display("FAIL mrst_no_ack2: got %b required 0", snap_ack); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_startup_and_mux();
        test_frozen();
        test_coincident();
        test_enable_drop();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
